hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline sequencing controller for the five-stage rv32i pipeline. It decides every cycle which pipeline registers load, when a load-use bubble is inserted, and when a branch mispredict flushes IF/ID and ID/EX. It drives the decode stage's `branch_recovery`, `overwrite_load`, `rs1_prev` and `rs2_prev` inputs. It sits beside the datapath and is fed by decode, execute and both caches.

## Interface
Parameters:
- CNT_WIDTH, 16, width of each saturating performance counter

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- id_rs1, id_rs2  in  5 each  source register fields from IF/ID
- id_uses_rs1, id_uses_rs2  in  1 each  decoded instruction reads rs1 / rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_mem_read  in  1  instruction in EX is a load
- ex_mispredict  in  1  single-cycle pulse: EX resolved a branch opposite to its prediction
- if_req, icache_resp  in  1 each  instruction fetch outstanding / fetch complete
- dmem_req, dcache_resp  in  1 each  data access outstanding / data access complete
- pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load  out  1 each  pipeline register enables
- id_ex_bubble  out  1  ID/EX captures a NOP (zero control word, rd=0)
- branch_recovery  out  1  squash IF/ID contents and the decode outputs; PC takes the EX target
- overwrite_load  out  1  decode reads the regfile with rs1_prev/rs2_prev
- rs1_prev, rs2_prev  out  5 each  held source addresses
- lu_stall_cnt, flush_cnt  out  CNT_WIDTH each  saturating event counters

## Operation
Derived terms:
- mem_stall = dmem_req & ~dcache_resp
- if_stall = if_req & ~icache_resp
- load_use = ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd))

States are RUN and RECOVER_PEND. The following priority applies each cycle, in state RUN:
1. mem_stall: all five enables are 0. No bubble. If ex_mispredict is asserted, latch it and go to RECOVER_PEND.
2. ex_mispredict with if_stall: all enables are 0. Go to RECOVER_PEND.
3. ex_mispredict: branch_recovery=1 and all enables are 1. flush_cnt increments. load_use is ignored.
4. load_use: pc_load=0 and if_id_load=0. id_ex_bubble=1. Other enables are 1. lu_stall_cnt increments.
5. if_stall: pc_load=0 and if_id_load=0. id_ex_bubble=1. Other enables are 1.
6. Otherwise all enables are 1.

In state RECOVER_PEND:
- All enables are 0 while mem_stall | if_stall.
- On the first cycle with neither condition, apply rule 3 and return to RUN.
- A further ex_mispredict pulse while pending is merged into the pending recovery, not queued.

Operand-address hold:
- overwrite_load is a register: it is 1 in the cycle after any cycle with if_id_load=0, otherwise 0.
- rs1_prev and rs2_prev capture id_rs1 and id_rs2 in every cycle with overwrite_load=0. They hold otherwise.

Counters saturate at all-ones and never wrap.

## Timing
- Reset (rst_n low, asynchronous): state=RUN, overwrite_load=0, rs1_prev=rs2_prev=0, both counters=0.
- While rst_n is low, every enable, id_ex_bubble and branch_recovery is forced to 0. Asserting reset mid-RECOVER_PEND discards the pending recovery.
- Enables, bubble and branch_recovery are combinational from inputs and state, giving zero-cycle response.
- State, overwrite_load, rs*_prev and counters update on the rising edge of clk.
- A load-use stall lasts exactly 1 cycle. The next cycle, EX holds the bubble, so load_use=0.
- The recovery latency from the ex_mispredict pulse is 0 cycles in RUN. When deferred, recovery occurs N cycles later, where N is the number of remaining stall cycles.
- A mem_stall that coincides with load_use inserts no bubble and does not increment the counter. The hazard is re-evaluated after the stall clears.

## Structure
- The shared package `rv32i_types` gains `hazard_state_t` (enum RUN, RECOVER_PEND).
- One sub-module, `sat_counter` (parameter width; ports clk, rst_n, inc, count), is instantiated twice.

## Test plan
- Load-use: `lw x5` in EX, `add x6,x5,x1` in IF/ID (id_rs1=5, id_uses_rs1=1). Required response:
  - Exactly one cycle of pc_load=0, if_id_load=0, id_ex_bubble=1.
  - overwrite_load=1 the following cycle with rs1_prev=5.
  - lu_stall_cnt goes 0 to 1.
- rd=0 and unused source: ex_rd=0 matching id_rs1=0, or a match with id_uses_rs2=0. Required response: no stall, all enables 1.
- Mispredict in RUN: one-cycle ex_mispredict pulse with no stalls. Required response: branch_recovery=1 in the same cycle, all enables 1, flush_cnt goes to 1.
- Mispredict under a data miss: ex_mispredict pulses in the first cycle of a 3-cycle mem_stall. Required response:
  - All enables are 0 for 3 cycles.
  - branch_recovery=1 in cycle 4.
  - State is RUN in cycle 5.
- Priority: load_use and ex_mispredict in the same cycle. Required response: branch_recovery=1, id_ex_bubble=0, lu_stall_cnt unchanged.
- Reset and saturation:
  - Assert rst_n=0 mid-RECOVER_PEND. Required response: all outputs go to 0 immediately, and no recovery follows release.
  - Force lu_stall_cnt to 16'hFFFF and apply another load_use. Required response: the count stays at 16'hFFFF.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the rv32i pipeline.
package rv32i_types;

    typedef enum logic {
        RUN          = 1'b0,
        RECOVER_PEND = 1'b1
    } hazard_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: register enables, load-use bubbles, mispredict flushes.
//   state        | meaning
//   RUN          | normal sequencing
//   RECOVER_PEND | mispredict seen during a stall, flush waits for the stall to clear
module hazard_controller
    import rv32i_types::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [4:0]           ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_mispredict,
    input  logic                 if_req,
    input  logic                 icache_resp,
    input  logic                 dmem_req,
    input  logic                 dcache_resp,
    output logic                 pc_load,
    output logic                 if_id_load,
    output logic                 id_ex_load,
    output logic                 ex_mem_load,
    output logic                 mem_wb_load,
    output logic                 id_ex_bubble,
    output logic                 branch_recovery,
    output logic                 overwrite_load,
    output logic [4:0]           rs1_prev,
    output logic [4:0]           rs2_prev,
    output logic [CNT_WIDTH-1:0] lu_stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    hazard_state_t state, state_next;
    logic          mem_stall, if_stall, load_use;
    logic          lu_inc, flush_inc;

    assign mem_stall = dmem_req & ~dcache_resp;
    assign if_stall  = if_req & ~icache_resp;
    assign load_use  = ex_mem_read && (ex_rd != REG_ZERO) &&
                       ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                        (id_uses_rs2 && (id_rs2 == ex_rd)));

    // Everything defaults to frozen; reset keeps it that way.
    always_comb begin
        state_next      = state;
        pc_load         = 1'b0;
        if_id_load      = 1'b0;
        id_ex_load      = 1'b0;
        ex_mem_load     = 1'b0;
        mem_wb_load     = 1'b0;
        id_ex_bubble    = 1'b0;
        branch_recovery = 1'b0;
        lu_inc          = 1'b0;
        flush_inc       = 1'b0;
        if (rst_n) begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        if (ex_mispredict) state_next = RECOVER_PEND;
                    end else if (ex_mispredict && if_stall) begin
                        state_next = RECOVER_PEND;
                    end else if (ex_mispredict) begin
                        {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load} = '1;
                        branch_recovery = 1'b1;
                        flush_inc       = 1'b1;
                    end else if (load_use || if_stall) begin
                        {id_ex_load, ex_mem_load, mem_wb_load} = '1;
                        id_ex_bubble = 1'b1;
                        lu_inc       = load_use;
                    end else begin
                        {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load} = '1;
                    end
                end
                RECOVER_PEND: begin
                    if (!(mem_stall || if_stall)) begin
                        {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load} = '1;
                        branch_recovery = 1'b1;
                        flush_inc       = 1'b1;
                        state_next      = RUN;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RUN;
            overwrite_load <= 1'b0;
            rs1_prev       <= '0;
            rs2_prev       <= '0;
        end else begin
            state          <= state_next;
            overwrite_load <= ~if_id_load;
            if (!overwrite_load) begin
                rs1_prev <= id_rs1;
                rs2_prev <= id_rs2;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_lu_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (lu_inc),
        .count (lu_stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed plus random bench for hazard_controller against a behavioural model.
module tb_hazard_controller;

    localparam int CW   = 16;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs1, id_uses_rs2, ex_mem_read, ex_mispredict;
    logic          if_req, icache_resp, dmem_req, dcache_resp;
    logic          pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic          id_ex_bubble, branch_recovery, overwrite_load;
    logic [4:0]    rs1_prev, rs2_prev;
    logic [CW-1:0] lu_stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    // model state
    bit         m_pend;
    bit         m_ow;
    logic [4:0] m_p1, m_p2;
    int         m_lu, m_fl;

    hazard_controller #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mispredict(ex_mispredict),
        .if_req(if_req), .icache_resp(icache_resp),
        .dmem_req(dmem_req), .dcache_resp(dcache_resp),
        .pc_load(pc_load), .if_id_load(if_id_load), .id_ex_load(id_ex_load),
        .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
        .id_ex_bubble(id_ex_bubble), .branch_recovery(branch_recovery),
        .overwrite_load(overwrite_load), .rs1_prev(rs1_prev), .rs2_prev(rs2_prev),
        .lu_stall_cnt(lu_stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, want);
            $error("%s disagrees with model", tag);
        end
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rd = 5'd0; ex_mem_read = 1'b0; ex_mispredict = 1'b0;
        if_req = 1'b0; icache_resp = 1'b0; dmem_req = 1'b0; dcache_resp = 1'b0;
    endtask

    // Called just after inputs are driven at a negedge; checks then advances the model.
    task automatic cycle();
        bit         ms, is, lu, want_rec, freeze;
        logic [6:0] want;
        #1;
        if (!rst_n) begin
            m_pend = 0; m_ow = 0; m_p1 = '0; m_p2 = '0; m_lu = 0; m_fl = 0;
        end
        ms = dmem_req && !dcache_resp;
        is = if_req && !icache_resp;
        lu = ex_mem_read && (ex_rd != 0) &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        want_rec = m_pend || ex_mispredict;
        freeze   = ms || (want_rec && is);
        // bit order: pc, if_id, id_ex, ex_mem, mem_wb, bubble, recovery
        if (!rst_n || freeze)  want = 7'b00000_0_0;
        else if (want_rec)     want = 7'b11111_0_1;
        else if (lu || is)     want = 7'b00111_1_0;
        else                   want = 7'b11111_0_0;

        chk("ctrl", {25'd0, pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                     id_ex_bubble, branch_recovery}, {25'd0, want});
        chk("overwrite_load", {31'd0, overwrite_load}, {31'd0, m_ow});
        chk("rs1_prev", {27'd0, rs1_prev}, {27'd0, m_p1});
        chk("rs2_prev", {27'd0, rs2_prev}, {27'd0, m_p2});
        chk("lu_stall_cnt", {16'd0, lu_stall_cnt}, 32'(m_lu));
        chk("flush_cnt", {16'd0, flush_cnt}, 32'(m_fl));

        if (rst_n) begin
            if (!m_ow) begin m_p1 = id_rs1; m_p2 = id_rs2; end
            m_ow = !want[5];
            if (want[0] && m_fl < MAXC) m_fl++;
            if (!want_rec && !freeze && lu && m_lu < MAXC) m_lu++;
            m_pend = freeze && want_rec;
        end
    endtask

    task automatic set_lu();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        id_rs2 = 5'd1; id_uses_rs2 = 1'b1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        m_pend = 0; m_ow = 0; m_p1 = '0; m_p2 = '0; m_lu = 0; m_fl = 0;

        // reset
        @(negedge clk); cycle();
        @(negedge clk); cycle();
        @(negedge clk); rst_n = 1'b1; cycle();

        // load-use: lw x5 in EX, add x6,x5,x1 in IF/ID
        @(negedge clk); idle(); set_lu(); cycle();
        chk("lu_bubble", {31'd0, id_ex_bubble}, 32'd1);
        chk("lu_pc_hold", {31'd0, pc_load}, 32'd0);
        @(negedge clk); ex_mem_read = 1'b0; ex_rd = 5'd0; cycle();
        chk("lu_next_ow", {31'd0, overwrite_load}, 32'd1);
        chk("lu_next_rs1", {27'd0, rs1_prev}, 32'd5);
        chk("lu_next_bubble", {31'd0, id_ex_bubble}, 32'd0);
        chk("lu_cnt_one", {16'd0, lu_stall_cnt}, 32'd1);

        // rd=0 and unused source
        @(negedge clk); idle(); ex_mem_read = 1'b1; id_uses_rs1 = 1'b1; cycle();
        chk("rd0_no_stall", {31'd0, pc_load}, 32'd1);
        @(negedge clk); ex_rd = 5'd7; id_rs2 = 5'd7; id_rs1 = 5'd3; id_uses_rs2 = 1'b0; cycle();
        chk("unused_no_stall", {31'd0, if_id_load}, 32'd1);

        // mispredict in RUN
        @(negedge clk); idle(); ex_mispredict = 1'b1; cycle();
        chk("mp_recovery", {31'd0, branch_recovery}, 32'd1);
        @(negedge clk); idle(); cycle();
        chk("mp_flush_one", {16'd0, flush_cnt}, 32'd1);

        // mispredict in first cycle of a 3-cycle data miss
        @(negedge clk); idle(); dmem_req = 1'b1; ex_mispredict = 1'b1; cycle();
        @(negedge clk); ex_mispredict = 1'b0; cycle();
        @(negedge clk); cycle();
        chk("miss_frozen", {31'd0, mem_wb_load}, 32'd0);
        @(negedge clk); dcache_resp = 1'b1; cycle();
        chk("miss_recovery_c4", {31'd0, branch_recovery}, 32'd1);
        @(negedge clk); idle(); cycle();
        chk("miss_run_c5", {31'd0, branch_recovery}, 32'd0);

        // load_use and mispredict together
        @(negedge clk); idle(); set_lu(); ex_mispredict = 1'b1; cycle();
        chk("prio_no_bubble", {31'd0, id_ex_bubble}, 32'd0);
        chk("prio_recovery", {31'd0, branch_recovery}, 32'd1);

        // reset asserted while a recovery is pending
        @(negedge clk); idle(); if_req = 1'b1; ex_mispredict = 1'b1; cycle();
        @(negedge clk); ex_mispredict = 1'b0; rst_n = 1'b0; cycle();
        chk("rst_pend_ctrl", {31'd0, id_ex_load}, 32'd0);
        @(negedge clk); idle(); rst_n = 1'b1; cycle();
        chk("rst_no_recovery", {31'd0, branch_recovery}, 32'd0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            id_rs1        = 5'($urandom_range(0, 3));
            id_rs2        = 5'($urandom_range(0, 3));
            id_uses_rs1   = 1'($urandom);
            id_uses_rs2   = 1'($urandom);
            ex_rd         = 5'($urandom_range(0, 3));
            ex_mem_read   = 1'($urandom);
            ex_mispredict = ($urandom_range(0, 7) == 0);
            if_req        = ($urandom_range(0, 3) == 0);
            icache_resp   = 1'($urandom);
            dmem_req      = ($urandom_range(0, 3) == 0);
            dcache_resp   = 1'($urandom);
            cycle();
        end

        // saturation: hold a load-use condition long enough to reach all-ones
        @(negedge clk); idle(); rst_n = 1'b0; cycle();
        @(negedge clk); rst_n = 1'b1; set_lu(); cycle();
        for (int i = 0; i < MAXC + 4; i++) begin
            @(negedge clk); cycle();
        end
        chk("lu_saturated", {16'd0, lu_stall_cnt}, 32'h0000FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
